// File: rtl/pht_gshare_ctrl_pkg.sv
// Shared branch-predictor definitions: controller FSM encoding and counter limits.
package pht_gshare_ctrl_pkg;

  localparam int PKG_CNT_W = 3;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    UPD_RD = 2'd1,
    UPD_WR = 2'd2
  } pht_state_e;

  localparam logic [PKG_CNT_W-1:0] CNT_MAX = 3'd7;
  localparam logic [PKG_CNT_W-1:0] CNT_MIN = 3'd0;
  localparam int                   CNT_TAKEN_BIT = PKG_CNT_W - 1;

endpackage

// File: rtl/pht_gshare_ctrl_sat_counter_next.sv
// Next value of a saturating direction counter; purely combinational, no backpressure.
// Saturates at CNT_MAX/CNT_MIN and never wraps.
module sat_counter_next
  import pht_gshare_ctrl_pkg::*;
(
  input  logic [PKG_CNT_W-1:0] i_old,
  input  logic                 i_taken,
  output logic [PKG_CNT_W-1:0] o_new
);

  always_comb begin
    o_new = i_old;
    if (i_taken && (i_old != CNT_MAX)) begin
      o_new = i_old + 1'b1;
    end else if (!i_taken && (i_old != CNT_MIN)) begin
      o_new = i_old - 1'b1;
    end
  end

endmodule

// File: rtl/pht_gshare_ctrl.sv
// Gshare PHT controller: 1-cycle prediction, 3-cycle read-modify-write update on the shared table port.
// Updates win arbitration; PredReady/UpdReady stay low through UPD_RD and UPD_WR.
module pht_gshare_ctrl
  import pht_gshare_ctrl_pkg::*;
#(
  parameter int PC_W   = 32,
  parameter int IDX_W  = 8,
  parameter int CNT_W  = 3,
  parameter int PERF_W = 32
) (
  input  logic              Clk,
  input  logic              Rest,
  input  logic              PredValid,
  input  logic [PC_W-1:0]   PredPc,
  output logic              PredReady,
  output logic              PredOutValid,
  output logic              PredTaken,
  output logic [IDX_W-1:0]  PredIndex,
  input  logic              UpdValid,
  input  logic [IDX_W-1:0]  UpdIndex,
  input  logic              UpdTaken,
  output logic              UpdReady,
  output logic [IDX_W-1:0]  TblAddr,
  output logic              TblWen,
  output logic [CNT_W-1:0]  TblDin,
  input  logic [CNT_W-1:0]  TblDout,
  output logic [IDX_W-1:0]  Ghr,
  output logic [PERF_W-1:0] MispredCnt
);

  pht_state_e       r_state;
  pht_state_e       w_state_nxt;
  logic [IDX_W-1:0] r_ghr;
  logic [PERF_W-1:0] r_mispred;
  logic             r_pred_pend;
  logic [IDX_W-1:0] r_pred_idx;
  logic             r_pred_taken;
  logic [IDX_W-1:0] r_upd_idx;
  logic             r_upd_taken;

  logic             w_pred_acc;
  logic             w_upd_acc;
  logic [IDX_W-1:0] w_hash;
  logic [CNT_W-1:0] w_cnt_new;
  logic             w_unused_pc;

  assign w_hash      = PredPc[IDX_W+1:2] ^ r_ghr;
  assign w_unused_pc = ^{PredPc[PC_W-1:IDX_W+2], PredPc[1:0]};

  sat_counter_next u_sat (
    .i_old   (TblDout),
    .i_taken (r_upd_taken),
    .o_new   (w_cnt_new)
  );

  always_comb begin
    w_state_nxt = r_state;
    PredReady   = 1'b0;
    UpdReady    = 1'b0;
    TblAddr     = '0;
    TblWen      = 1'b0;
    TblDin      = '0;
    w_pred_acc  = 1'b0;
    w_upd_acc   = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (UpdValid) begin
          UpdReady    = 1'b1;
          w_upd_acc   = 1'b1;
          TblAddr     = UpdIndex;
          w_state_nxt = UPD_RD;
        end else begin
          PredReady = 1'b1;
          if (PredValid) begin
            w_pred_acc = 1'b1;
            TblAddr    = w_hash;
          end
        end
      end
      UPD_RD: begin
        TblAddr     = r_upd_idx;
        TblDin      = w_cnt_new;
        TblWen      = 1'b1;
        w_state_nxt = UPD_WR;
      end
      UPD_WR:  w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
    // Table port and handshakes go quiet the instant reset asserts, not at the next edge.
    if (!Rest) begin
      PredReady  = 1'b0;
      UpdReady   = 1'b0;
      TblAddr    = '0;
      TblWen     = 1'b0;
      TblDin     = '0;
      w_pred_acc = 1'b0;
      w_upd_acc  = 1'b0;
    end
  end

  always_ff @(posedge Clk or negedge Rest) begin
    if (!Rest) begin
      r_state      <= IDLE;
      r_ghr        <= '0;
      r_mispred    <= '0;
      r_pred_pend  <= 1'b0;
      r_pred_idx   <= '0;
      r_pred_taken <= 1'b0;
      r_upd_idx    <= '0;
      r_upd_taken  <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_pred_pend <= w_pred_acc;
      if (w_pred_acc) begin
        r_pred_idx <= w_hash;
      end
      if (r_pred_pend) begin
        r_pred_taken <= TblDout[CNT_TAKEN_BIT];
      end
      if (w_upd_acc) begin
        r_upd_idx   <= UpdIndex;
        r_upd_taken <= UpdTaken;
      end
      if (r_state == UPD_RD) begin
        r_ghr <= {r_ghr[IDX_W-2:0], r_upd_taken};
        if (TblDout[CNT_TAKEN_BIT] != r_upd_taken) begin
          r_mispred <= r_mispred + 1'b1;
        end
      end
    end
  end

  assign PredOutValid = r_pred_pend;
  assign PredTaken    = r_pred_pend ? TblDout[CNT_TAKEN_BIT] : r_pred_taken;
  assign PredIndex    = r_pred_idx;
  assign Ghr          = r_ghr;
  assign MispredCnt   = r_mispred;

endmodule

// File: doc/pht_gshare_ctrl.md
Name: pht_gshare_ctrl

Overview:
- Control stage for the 256-entry, 3-bit saturating-counter pattern history table (PHT) in the branch predictor.
- Hashes fetch PC with a global history register (GHR) into an 8-bit table index and returns the taken/not-taken prediction.
- Performs the read-modify-write saturating update when a branch resolves.
- Sole owner of the table's single shared port (address, write enable, write data, 1-cycle registered read data).

Parameters:
- PC_W, 32, fetch/resolve PC width.
- IDX_W, 8, table index width and GHR width; fixed by the 256-entry table.
- CNT_W, 3, counter width; MSB set means predict taken.
- PERF_W, 32, width of the mispredict performance counter.

Ports:
- Clk  in  1  system clock, rising edge.
- Rest  in  1  reset; asynchronous, active-low.
- PredValid  in  1  prediction request.
- PredPc  in  PC_W  branch PC.
- PredReady  out  1  request accepted this cycle.
- PredOutValid  out  1  prediction result valid.
- PredTaken  out  1  predicted direction.
- PredIndex  out  IDX_W  index used; the branch carries it to resolve.
- UpdValid  in  1  branch resolved.
- UpdIndex  in  IDX_W  index returned from PredIndex.
- UpdTaken  in  1  actual direction.
- UpdReady  out  1  update accepted this cycle.
- TblAddr  out  IDX_W  table address.
- TblWen  out  1  table write enable.
- TblDin  out  CNT_W  table write data.
- TblDout  in  CNT_W  table read data, registered, valid 1 cycle after TblAddr.
- Ghr  out  IDX_W  current global history, for debug.
- MispredCnt  out  PERF_W  count of resolved updates whose old counter MSB differed from UpdTaken.

Behaviour:
- Reset (Rest low, asynchronous): FSM goes to IDLE. Ghr=0, MispredCnt=0. PredOutValid=0, PredTaken=0, PredIndex=0. TblWen=0, TblAddr=0, TblDin=0. Any in-flight update is abandoned and no table write is issued.
- FSM states: IDLE, UPD_RD, UPD_WR.
- IDLE arbitration: updates have priority over predictions.
  - If UpdValid=1: UpdReady=1 and PredReady=0. Latch UpdIndex and UpdTaken. Drive TblAddr=UpdIndex with TblWen=0. Next state is UPD_RD.
  - Else: PredReady=1 and UpdReady=0. If PredValid=1, drive TblAddr = PredPc[IDX_W+1:2] ^ Ghr with TblWen=0, and register the index and a pending flag.
- Prediction latency is 1 cycle.
  - In the cycle after acceptance: PredOutValid=1, PredTaken=TblDout[CNT_W-1], PredIndex=the registered index.
  - Otherwise PredOutValid=0; PredTaken and PredIndex hold their last values.
  - Back-to-back predictions are accepted every IDLE cycle.
- UPD_RD (TblDout now holds the old counter):
  - new = (UpdTaken && old!=7) ? old+1 : (!UpdTaken && old!=0) ? old-1 : old. The counter saturates at 7 and 0 and never wraps.
  - Drive TblAddr=latched index, TblDin=new, TblWen=1 in this same cycle.
  - Ghr <= {Ghr[IDX_W-2:0], UpdTaken}.
  - If old[CNT_W-1] != UpdTaken, MispredCnt increments. It wraps modulo 2^PERF_W.
  - Next state is UPD_WR.
- UPD_WR: bubble cycle so the write retires before the next read. TblWen=0; PredReady=0; UpdReady=0. Next state is IDLE.
- An update occupies the port for 3 cycles (IDLE accept, UPD_RD, UPD_WR). PredReady and UpdReady are both 0 in UPD_RD and UPD_WR.
- A prediction issued right after an update to the same index must read the new value; the WR bubble guarantees this.
- Ghr changes only on resolved updates, never speculatively. A prediction accepted in a cycle uses the Ghr value of that cycle.
- Simultaneous PredValid and UpdValid in IDLE: the update wins and the prediction stays pending upstream. The requester must hold PredValid and PredPc until PredReady.
- TblWen is never asserted outside UPD_RD.

Decomposition:
- Shared predictor package holds:
  - FSM state encoding: IDLE=2'd0, UPD_RD=2'd1, UPD_WR=2'd2.
  - Constants CNT_MAX=3'd7, CNT_MIN=3'd0, and the taken threshold (counter MSB).
- One natural sub-module: sat_counter_next. Combinational; inputs old counter and taken, output next counter. It is reused by future BTB/selector tables.

Test Plan:
- Reset then prediction: Ghr=0, PredPc=0x0000_0010 → TblAddr=0x04. One cycle later PredOutValid=1, PredTaken=0 (table holds 0), PredIndex=0x04.
- Saturating increment: drive UpdIndex=0x04, UpdTaken=1 eight times with the table entry starting at 0. Required writes are 1,2,3,4,5,6,7,7; the last write stays 7. MispredCnt ends at 4 (olds 0..3 have MSB=0). Ghr=0xFF.
- Saturating decrement: from entry 0x04 at 7, apply eight not-taken updates. Required writes are 6,5,4,3,2,1,0,0. Ghr shifts in zeros.
- Collision: PredValid and UpdValid both high in IDLE → UpdReady=1 and PredReady=0. PredReady is 0 for two more cycles and returns to 1 in the fourth cycle. The held prediction to the same index then returns the post-update MSB.
- Hash and history: after updates T,N,T (Ghr=0x05), PredPc=0x0000_0020 → TblAddr = 0x08^0x05 = 0x0D.
- Reset mid-update: assert Rest low during UPD_RD → TblWen drops to 0 immediately, FSM returns to IDLE, Ghr=0, MispredCnt=0, and no table write occurs after release.
